// File: rtl/trafficlight_pkg.sv
// Shared constants for the traffic-light monitor: light codes, fault codes and state encoding.
package trafficlight_pkg;

  localparam logic [1:0] LIGHT_OFF    = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_GREEN  = 2'b11;

  localparam logic [2:0] FLT_NONE      = 3'd0;
  localparam logic [2:0] FLT_CODE      = 3'd1;
  localparam logic [2:0] FLT_SEQ       = 3'd2;
  localparam logic [2:0] FLT_RED_OVR   = 3'd3;
  localparam logic [2:0] FLT_GRN_OVR   = 3'd4;
  localparam logic [2:0] FLT_YEL_OVR   = 3'd5;
  localparam logic [2:0] FLT_YEL_SHORT = 3'd6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RED    = 3'd1;
  localparam logic [2:0] ST_GREEN  = 3'd2;
  localparam logic [2:0] ST_YELLOW = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

endpackage

// File: rtl/trafficlight_dwell_ctr.sv
// Saturating phase-dwell counter: clear to 0, load 1 on phase entry, increment, or hold.
module trafficlight_dwell_ctr #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               load1_i,
  input  logic               inc_i,
  output logic [DWELL_W-1:0] dwell_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = DWELL_W'(1);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign dwell_o = cnt_q;

endmodule

// File: rtl/trafficlight_monitor.sv
// Traffic-light code monitor: lamp decode, phase/dwell tracking, sticky fault with cause code.
// Optional macro TRAFFICLIGHT_MONITOR_FLASH_EN: blink the red lamp while in FAULT.
module trafficlight_monitor
  import trafficlight_pkg::*;
#(
  parameter int RED_MAX    = 64,
  parameter int GREEN_MAX  = 64,
  parameter int YELLOW_MIN = 6,
  parameter int YELLOW_MAX = 8,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         light,
  input  logic               clear_fault,
  output logic               lamp_red,
  output logic               lamp_yellow,
  output logic               lamp_green,
  output logic               fault,
  output logic [2:0]         fault_code,
  output logic [DWELL_W-1:0] dwell,
  output logic [15:0]        cycle_count
);

  // state  | meaning
  // IDLE   | waiting for first RED; other codes ignored (controller may be unreset)
  // RED    | red phase, dwell counting
  // GREEN  | green phase, no minimum length
  // YELLOW | yellow phase, must last YELLOW_MIN before RED
  // FAULT  | sticky violation, light ignored until clear_fault

  localparam logic [DWELL_W-1:0] RED_MAX_C = DWELL_W'(RED_MAX);
  localparam logic [DWELL_W-1:0] GRN_MAX_C = DWELL_W'(GREEN_MAX);
  localparam logic [DWELL_W-1:0] YEL_MIN_C = DWELL_W'(YELLOW_MIN);
  localparam logic [DWELL_W-1:0] YEL_MAX_C = DWELL_W'(YELLOW_MAX);

  logic [2:0]  state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] cc_q, cc_d;
  logic [2:0]  lamps_q, lamps_d;
  logic        fault_q;
  logic        dw_clr, dw_load1, dw_inc;
  logic        flash_red;

  trafficlight_dwell_ctr #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (dw_clr),
    .load1_i (dw_load1),
    .inc_i   (dw_inc),
    .dwell_o (dwell)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cc_d     = cc_q;
    dw_clr   = 1'b0;
    dw_load1 = 1'b0;
    dw_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (light == LIGHT_RED) begin
          state_d  = ST_RED;
          dw_load1 = 1'b1;
        end
      end
      ST_RED: begin
        case (light)
          LIGHT_RED: begin
            if (dwell == RED_MAX_C) begin
              state_d = ST_FAULT;
              code_d  = FLT_RED_OVR;
            end else begin
              dw_inc = 1'b1;
            end
          end
          LIGHT_GREEN: begin
            state_d  = ST_GREEN;
            dw_load1 = 1'b1;
          end
          LIGHT_YELLOW: begin
            state_d = ST_FAULT;
            code_d  = FLT_SEQ;
          end
          default: begin
            state_d = ST_FAULT;
            code_d  = FLT_CODE;
          end
        endcase
      end
      ST_GREEN: begin
        case (light)
          LIGHT_GREEN: begin
            if (dwell == GRN_MAX_C) begin
              state_d = ST_FAULT;
              code_d  = FLT_GRN_OVR;
            end else begin
              dw_inc = 1'b1;
            end
          end
          LIGHT_YELLOW: begin
            state_d  = ST_YELLOW;
            dw_load1 = 1'b1;
          end
          LIGHT_RED: begin
            state_d = ST_FAULT;
            code_d  = FLT_SEQ;
          end
          default: begin
            state_d = ST_FAULT;
            code_d  = FLT_CODE;
          end
        endcase
      end
      ST_YELLOW: begin
        case (light)
          LIGHT_YELLOW: begin
            if (dwell == YEL_MAX_C) begin
              state_d = ST_FAULT;
              code_d  = FLT_YEL_OVR;
            end else begin
              dw_inc = 1'b1;
            end
          end
          LIGHT_RED: begin
            if (dwell >= YEL_MIN_C) begin
              state_d  = ST_RED;
              dw_load1 = 1'b1;
              cc_d     = cc_q + 16'd1;
            end else begin
              state_d = ST_FAULT;
              code_d  = FLT_YEL_SHORT;
            end
          end
          LIGHT_GREEN: begin
            state_d = ST_FAULT;
            code_d  = FLT_SEQ;
          end
          default: begin
            state_d = ST_FAULT;
            code_d  = FLT_CODE;
          end
        endcase
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_IDLE;
          code_d  = FLT_NONE;
          dw_clr  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = FLT_NONE;
        dw_clr  = 1'b1;
      end
    endcase
  end

`ifdef TRAFFICLIGHT_MONITOR_FLASH_EN
  logic [2:0] blink_q, blink_d;

  // Blink counter restarts on FAULT entry; red toggles each time it wraps.
  always_comb begin
    blink_d   = '0;
    flash_red = 1'b1;
    if (state_q == ST_FAULT) begin
      blink_d   = blink_q + 3'd1;
      flash_red = (blink_q == 3'd7) ? ~lamps_q[2] : lamps_q[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end
`else
  assign flash_red = 1'b1;
`endif

  always_comb begin
    lamps_d = 3'b000;
    case (state_d)
      ST_RED:    lamps_d = 3'b100;
      ST_YELLOW: lamps_d = 3'b010;
      ST_GREEN:  lamps_d = 3'b001;
      ST_FAULT:  lamps_d = {flash_red, 2'b00};
      default:   lamps_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= FLT_NONE;
      cc_q    <= '0;
      lamps_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cc_q    <= cc_d;
      lamps_q <= lamps_d;
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign lamp_red    = lamps_q[2];
  assign lamp_yellow = lamps_q[1];
  assign lamp_green  = lamps_q[0];
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = cc_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Scoreboard bench for trafficlight_monitor: driver queues hand-computed expectations, monitor compares.
module tb_trafficlight_monitor;

  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;

  logic        clk;
  logic        reset;
  logic [1:0]  light;
  logic        clear_fault;
  logic        lamp_red, lamp_yellow, lamp_green, fault;
  logic [2:0]  fault_code;
  logic [7:0]  dwell;
  logic [15:0] cycle_count;

  typedef struct {
    logic [30:0] vec;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  trafficlight_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .clear_fault (clear_fault),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .fault       (fault),
    .fault_code  (fault_code),
    .dwell       (dwell),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] pack(input logic [2:0] lamps, input logic flt,
                                       input logic [2:0] code, input logic [7:0] dw,
                                       input logic [15:0] cc);
    return {lamps, flt, code, dw, cc};
  endfunction

  // Expected red lamp k cycles after FAULT entry.
  function automatic logic [2:0] flt_lamp(input int k);
`ifdef TRAFFICLIGHT_MONITOR_FLASH_EN
    return ((k % 16) < 8) ? L_R : L_OFF;
`else
    return (k >= 0) ? L_R : L_OFF;
`endif
  endfunction

  task automatic drive(input logic [1:0] l, input logic clr, input logic [2:0] lamps,
                       input logic flt, input logic [2:0] code, input logic [7:0] dw,
                       input logic [15:0] cc, input string tag);
    exp_t e;
    @(negedge clk);
    light       = l;
    clear_fault = clr;
    e.vec = pack(lamps, flt, code, dw, cc);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [1:0] l, input int n, input logic [2:0] lamps,
                     input int dw0, input logic [15:0] cc, input string tag);
    for (int i = 0; i < n; i++)
      drive(l, 1'b0, lamps, 1'b0, 3'd0, 8'(dw0 + i), cc, tag);
  endtask

  // Monitor: outputs are valid every cycle, compare one expectation per edge.
  initial begin
    exp_t e;
    logic [30:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = pack({lamp_red, lamp_yellow, lamp_green}, fault, fault_code, dwell, cycle_count);
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL %s: got lamps=%b flt=%b code=%0d dwell=%0d cc=%0d, want lamps=%b flt=%b code=%0d dwell=%0d cc=%0d",
                   e.tag, act[30:28], act[27], act[26:24], act[23:16], act[15:0],
                   e.vec[30:28], e.vec[27], e.vec[26:24], e.vec[23:16], e.vec[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    light       = 2'bxx;
    clear_fault = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pack({lamp_red, lamp_yellow, lamp_green}, fault, fault_code, dwell, cycle_count) !== 31'd0) begin
      errors++;
      $display("FAIL reset_state: outputs not cleared during reset");
    end
    reset = 1'b0;

    // Nominal round, ignored codes in IDLE first
    drive(2'b11, 0, L_OFF, 0, 0, 0, 0, "idle_ign11");
    drive(2'b10, 0, L_OFF, 0, 0, 0, 0, "idle_ign10");
    drive(2'b00, 0, L_OFF, 0, 0, 0, 0, "idle_ign00a");
    drive(2'b00, 0, L_OFF, 0, 0, 0, 0, "idle_ign00b");
    drive(2'b00, 0, L_OFF, 0, 0, 0, 0, "idle_ign00c");
    run(2'b01, 51, L_R, 1, 0, "nom_red");
    run(2'b11, 51, L_G, 1, 0, "nom_green");
    run(2'b10, 6, L_Y, 1, 0, "nom_yellow");
    drive(2'b01, 0, L_R, 0, 0, 1, 1, "nom_round_done");

    // Early green cut; clear_fault outside FAULT is a no-op
    drive(2'b01, 1, L_R, 0, 0, 2, 1, "clr_outside_fault");
    run(2'b01, 8, L_R, 3, 1, "early_red");
    run(2'b11, 3, L_G, 1, 1, "early_green");
    run(2'b10, 6, L_Y, 1, 1, "early_yellow");
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "early_round_done");

    // Illegal RED->YELLOW at dwell 5
    run(2'b01, 4, L_R, 2, 2, "seq_red");
    drive(2'b10, 0, flt_lamp(0), 1, 2, 5, 2, "seq_fault");
    drive(2'b01, 0, flt_lamp(1), 1, 2, 5, 2, "seq_hold1");
    drive(2'b11, 0, flt_lamp(2), 1, 2, 5, 2, "seq_hold2");
    drive(2'b00, 1, L_OFF, 0, 0, 0, 2, "seq_clear");

    // Yellow short, clear, re-arm
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "ys_red");
    drive(2'b11, 0, L_G, 0, 0, 1, 2, "ys_green");
    run(2'b10, 4, L_Y, 1, 2, "ys_yellow");
    drive(2'b01, 0, flt_lamp(0), 1, 6, 4, 2, "ys_fault");
    drive(2'b10, 1, L_OFF, 0, 0, 0, 2, "ys_clear");
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "ys_rearm_red");

    // RED exactly MAX is legal, one more overruns; long FAULT hold
    run(2'b01, 63, L_R, 2, 2, "ovr_red");
    drive(2'b01, 0, flt_lamp(0), 1, 3, 64, 2, "ovr_red_fault");
    for (int k = 1; k < 10; k++)
      drive(2'(k), 0, flt_lamp(k), 1, 3, 64, 2, "ovr_red_hold");
    drive(2'b00, 1, L_OFF, 0, 0, 0, 2, "ovr_red_clear");

    // YELLOW overrun after 8
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "ovy_red");
    drive(2'b11, 0, L_G, 0, 0, 1, 2, "ovy_green");
    run(2'b10, 8, L_Y, 1, 2, "ovy_yellow");
    drive(2'b10, 0, flt_lamp(0), 1, 5, 8, 2, "ovr_yel_fault");
    drive(2'b00, 1, L_OFF, 0, 0, 0, 2, "ovy_clear");

    // GREEN overrun after 64
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "ovg_red");
    drive(2'b11, 0, L_G, 0, 0, 1, 2, "ovg_green1");
    run(2'b11, 63, L_G, 2, 2, "ovg_green");
    drive(2'b11, 0, flt_lamp(0), 1, 4, 64, 2, "ovr_grn_fault");
    drive(2'b00, 1, L_OFF, 0, 0, 0, 2, "ovg_clear");

    // Illegal code 00 in GREEN
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "c1_red");
    drive(2'b11, 0, L_G, 0, 0, 1, 2, "c1_green");
    drive(2'b00, 0, flt_lamp(0), 1, 1, 1, 2, "code1_fault");
    drive(2'b00, 1, L_OFF, 0, 0, 0, 2, "c1_clear");

    // Async reset mid-GREEN
    drive(2'b01, 0, L_R, 0, 0, 1, 2, "ar_red");
    drive(2'b11, 0, L_G, 0, 0, 1, 2, "ar_green1");
    run(2'b11, 3, L_G, 2, 2, "ar_green");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (pack({lamp_red, lamp_yellow, lamp_green}, fault, fault_code, dwell, cycle_count) !== 31'd0) begin
      errors++;
      $display("FAIL async_reset: got lamps=%b flt=%b code=%0d dwell=%0d cc=%0d, want all zero",
               {lamp_red, lamp_yellow, lamp_green}, fault, fault_code, dwell, cycle_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 0, L_OFF, 0, 0, 0, 0, "ar_idle_ign");
    drive(2'b01, 0, L_R, 0, 0, 1, 0, "ar_idle_to_red");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trafficlight_monitor.md
Name: trafficlight_monitor

Overview:
Receiving end of the 2-bit traffic-light code interface driven by the intersection controller. It decodes the `light` code into three one-hot lamp drives and tracks the phase sequence and per-phase dwell time. It raises a sticky fault with a code on any protocol violation. It sits between the controller and the lamp driver / supervisor, on the same clock as the controller.

Parameters:
- RED_MAX, 64: max cycles a RED phase may last.
- GREEN_MAX, 64: max cycles a GREEN phase may last.
- YELLOW_MIN, 6: min cycles a YELLOW phase must last before RED.
- YELLOW_MAX, 8: max cycles a YELLOW phase may last.
- DWELL_W, 8: dwell counter width; all MAX/MIN values must be < 2^DWELL_W.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- light, input, 2: controller code. 01=RED, 10=YELLOW, 11=GREEN, 00=illegal.
- clear_fault, input, 1: synchronous pulse; leaves FAULT and returns to IDLE.
- lamp_red / lamp_yellow / lamp_green, output, 1 each: registered one-hot lamp drives.
- fault, output, 1: sticky violation flag.
- fault_code, output, 3: cause of the first violation; 0 when fault=0.
- dwell, output, DWELL_W: cycles spent in the current phase; saturates at all-ones.
- cycle_count, output, 16: completed RED→GREEN→YELLOW→RED rounds; wraps at 2^16.

Behaviour:
- Reset values: state=IDLE, all lamps 0, fault=0, fault_code=0, dwell=0, cycle_count=0.
- `light` is sampled every posedge. All outputs are registered, so any output change lands one cycle after the `light` value that caused it.
- States: IDLE, RED, GREEN, YELLOW, FAULT.
- IDLE:
  - All lamps off.
  - Every code except 01 is ignored, including 00 and an X-free unknown. This tolerates the controller's unreset output register.
  - light=01 → RED, dwell=1.
- RED:
  - 01 → dwell+1.
  - 11 → GREEN, dwell=1.
  - 10 → FAULT, code 2 (illegal transition).
  - 00 → FAULT, code 1.
- GREEN:
  - 11 → dwell+1.
  - 10 → YELLOW, dwell=1. No minimum on green, because the controller may cut green early on the sensor.
  - 01 → FAULT, code 2.
  - 00 → FAULT, code 1.
- YELLOW:
  - 10 → dwell+1.
  - 01 with dwell ≥ YELLOW_MIN → RED, dwell=1, cycle_count+1.
  - 01 with dwell < YELLOW_MIN → FAULT, code 6 (yellow short).
  - 11 → FAULT, code 2.
  - 00 → FAULT, code 1.
- Overrun: a sampled code equal to the current phase while dwell==MAX for that phase → FAULT.
  - Code 3 for RED, 4 for GREEN, 5 for YELLOW.
  - A phase of exactly MAX cycles is legal.
- Lamps in RED/GREEN/YELLOW: exactly the matching lamp is 1.
- FAULT:
  - fault=1 and fault_code hold their values.
  - dwell freezes and cycle_count holds.
  - Lamps follow the optional feature.
  - `light` is ignored.
  - clear_fault=1 → IDLE, fault=0, code=0, dwell=0, lamps off.
- clear_fault outside FAULT has no effect.
- Only one violation is possible per sample. If classification overlaps, priority is code 1 > 2 > 6 > 3/4/5.
- Reset asserted mid-phase or in FAULT: immediate asynchronous return to reset values. cycle_count is also cleared.

Optional Feature:
- TRAFFICLIGHT_MONITOR_FLASH_EN defined: in FAULT, lamp_red toggles every 8 cycles, starting at 1 on FAULT entry; yellow and green are 0. A 3-bit blink counter is added.
- Undefined: in FAULT, lamp_red is held at a steady 1; yellow and green are 0.

Decomposition:
- Shared package trafficlight_pkg:
  - light code localparams LIGHT_RED=2'b01, LIGHT_YELLOW=2'b10, LIGHT_GREEN=2'b11, LIGHT_OFF=2'b00;
  - fault code constants FLT_NONE=0, FLT_CODE=1, FLT_SEQ=2, FLT_RED_OVR=3, FLT_GRN_OVR=4, FLT_YEL_OVR=5, FLT_YEL_SHORT=6;
  - the monitor state encoding.
- One natural sub-module, trafficlight_dwell_ctr: saturating DWELL_W counter with load-1, increment, and hold controls.

Test Plan:
- Nominal sequence: after reset, apply X then 00 for 3 cycles, then 01×51, 11×51, 10×6, 01×1. Expect no fault; lamps track the sequence one cycle late; cycle_count=1; dwell=1 after the final 01.
- Early green cut: 01×10, 11×3, 10×6, 01. Expect no fault; cycle_count=1.
- Illegal transition: in RED with dwell=5, apply 10. Next cycle fault=1, fault_code=2; lamps per the feature; dwell stays 5.
- Yellow short and clear: YELLOW×4 then 01 → fault_code=6. Pulse clear_fault → IDLE with fault=0 and lamps off. A following 01 → lamp_red=1.
- Overrun boundary: RED×64 gives no fault. RED×65 → fault_code=3 on the cycle after the 65th sample. Same check for YELLOW×9 → fault_code=5.
- Async reset: assert reset mid-GREEN between clock edges. Outputs clear immediately with no clock edge; cycle_count=0; the monitor returns to IDLE.
